byte_sram_ctrl: RTL and testbench
=================================

Name: byte_sram_ctrl

Overview:
- Request-side initiator for the 128x8 byte SRAM.
- Converts single and burst read/write commands into the SRAM's `wr_enable` / `rd_enable` / `ram_index` / `sram_data_in` strobes.
- Captures the SRAM's one-cycle-latency read data into a small response FIFO with valid/ready backpressure.
- Sits between any client (bus bridge, DMA, test sequencer) and the SRAM; it is the only driver of the SRAM's control inputs.

Parameters:
- ADDR_W, 7, SRAM index width (depth = 2**ADDR_W).
- DATA_W, 8, byte width.
- RSP_DEPTH, 4, read-response FIFO entries; minimum 4 to sustain one read per cycle.

Ports:
- sram_clk  in  1  clock.
- sram_ares  in  1  reset; synchronous, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start index.
- req_len  in  ADDR_W  beats minus 1 (1..128 beats).
- wdata_valid  in  1  write beat valid.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_W  write beat data.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response consumed.
- rsp_data  out  DATA_W  read response data.
- busy  out  1  burst in progress, or reads in flight, or FIFO non-empty.
- wr_enable  out  1  to SRAM.
- rd_enable  out  1  to SRAM.
- ram_index  out  ADDR_W  to SRAM.
- sram_data_in  out  DATA_W  to SRAM.
- sram_data_out  in  DATA_W  from SRAM.

Behaviour:
- Timing convention: cycle k is the period after clock edge k.
- Clock and reset: one clock. Reset is synchronous and active-high on sram_ares.
- Reset values: all outputs 0 except req_ready = 1. State = IDLE, FIFO and in-flight count cleared, address and beat counters 0.
- SRAM-side outputs (wr_enable, rd_enable, ram_index, sram_data_in) are registered.
- Invariant: wr_enable & rd_enable is never 1 in the same cycle. The SRAM treats that case as a stall and zeroes its output.
- FSM states are IDLE, WRITE and READ.
- IDLE:
  - req_ready = 1.
  - A handshake in cycle k loads the address and remaining-beats counters and enters WRITE or READ in cycle k+1.
  - Commands are accepted while the FIFO still holds data from an earlier read.
- WRITE:
  - wdata_ready = 1.
  - A beat accepted in cycle k drives wr_enable = 1, ram_index = current address, sram_data_in = wdata in cycle k+1.
  - No beat means wr_enable = 0 in the next cycle (bubble).
  - Address increments modulo 2**ADDR_W per beat (0x7F -> 0x00).
  - After the last beat is accepted, state returns to IDLE.
  - Beats presented while not in WRITE are ignored (wdata_ready = 0).
- READ:
  - A read is issued only if fifo_count + inflight < RSP_DEPTH (pops not credited in the same cycle).
  - An issue decided in cycle k drives rd_enable = 1 and ram_index in cycle k+1.
  - sram_data_out is valid in cycle k+2 only (the SRAM clears it on the next non-read cycle). It is pushed into the FIFO at the end of cycle k+2.
  - rsp_valid for that beat is asserted from cycle k+3.
  - Address wraps as in WRITE.
  - After the last issue, state returns to IDLE; in-flight beats still land in the FIFO.
  - With rsp_ready held at 1: one rd_enable per cycle, no bubbles.
- FIFO: responses delivered in issue order; never overflows; never drops data.
- req_ready = 0 in WRITE and READ.
- busy is the OR of: state != IDLE, inflight != 0, fifo_count != 0.
- Reset mid-burst: the burst is abandoned, the FIFO and in-flight beats are flushed, and all outputs take their reset values in the cycle after the reset edge. Partial writes already performed remain in the SRAM.

Test Plan:
- Write wrap-around: write req_addr = 0x7E, req_len = 3, wdata A0,A1,A2,A3 back-to-back -> wr_enable high 4 consecutive cycles with ram_index 7E,7F,00,01; then read the same range -> rsp_data A0,A1,A2,A3 in order.
- Full read burst: read req_addr = 0x00, req_len = 0x7F, rsp_ready = 1 -> rd_enable high 128 consecutive cycles; first rsp_valid 3 cycles after the first rd_enable cycle's decision point; 128 responses, correct data.
- Backpressure: read burst of 16 with rsp_ready = 0 -> rd_enable stops after exactly RSP_DEPTH (4) issues; release rsp_ready -> all 16 delivered in order, none lost or duplicated.
- Write gaps: write burst of 4 with wdata_valid toggling 1,0,1,0,... -> wr_enable only in the cycles after accepted beats; rd_enable = 0 throughout; no cycle with both enables high.
- Reset mid-read: assert sram_ares in beat 5 of a 32-beat read -> next cycle rsp_valid = 0, rd_enable = 0, busy = 0, req_ready = 1; a new read returns correct data with no stale responses.
- Busy lockout: second req_valid asserted during a write burst -> req_ready = 0 until the burst ends; the command is accepted in the first IDLE cycle and executed with its original fields.

Source files
------------

// File: rtl/byte_sram_ctrl_if.sv
// Client-side command / write-data / read-response bundle for byte_sram_ctrl.
// Latency: none (wires only).
// Backpressure: valid/ready on all three channels; busy is a status flag.
// Ports: req_* command channel, wdata* write beat channel, rsp_* read response
// channel, busy status. master = client, slave = controller.
interface byte_sram_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata, rsp_ready,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata, rsp_ready,
        output req_ready, wdata_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/byte_sram_ctrl.sv
// Request-side initiator for a 2**ADDR_W x DATA_W SRAM: single/burst commands -> registered SRAM strobes.
// Latency: strobe 1 cycle after beat accept / issue decision; read response valid 3 cycles after issue decision.
// Backpressure: reads issue only while fifo_count + inflight < RSP_DEPTH; req_ready low during any burst.
// Ports: sram_clk/sram_ares (sync, active-high) clock/reset; bus = client interface (slave modport);
// wr_enable/rd_enable/ram_index/sram_data_in drive the SRAM; sram_data_out is its read data.
module byte_sram_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic              sram_clk,
    input  logic              sram_ares,
    byte_sram_ctrl_if.slave   bus,
    output logic              wr_enable,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] ram_index,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;   // beats left minus 1; zero means current beat is the last
    logic              rd_land;    // read strobed last cycle: sram_data_out holds its byte now

    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              beat;
    logic              issue;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.wdata_ready = (state == S_WRITE);
    assign bus.rsp_valid   = (fifo_count != '0);
    assign bus.rsp_data    = bus.rsp_valid ? fifo_mem[rd_ptr] : '0;
    // rd_enable and rd_land together are the in-flight reads (at most one per stage).
    assign bus.busy        = (state != S_IDLE) | rd_enable | rd_land | (fifo_count != '0);

    assign accept = bus.req_valid & bus.req_ready;
    assign beat   = bus.wdata_valid & (state == S_WRITE);
    assign push   = rd_land;
    assign pop    = bus.rsp_valid & bus.rsp_ready;

    // Every slot is reserved at issue time; a pop in the same cycle is not
    // credited, which keeps the check off the rsp_ready timing path.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(rd_enable) + OCC_W'(rd_land);
    assign issue     = (state == S_READ) & (occupancy < DEPTH_C);

    always_ff @(posedge sram_clk) begin
        if (sram_ares) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            wr_enable    <= 1'b0;
            rd_enable    <= 1'b0;
            rd_land      <= 1'b0;
            ram_index    <= '0;
            sram_data_in <= '0;
        end else begin
            // Only one of beat/issue can be set (state-exclusive), so the
            // two enables never overlap.
            wr_enable <= beat;
            rd_enable <= issue;
            rd_land   <= rd_enable;
            if (beat) begin
                sram_data_in <= bus.wdata;
            end
            if (beat | issue) begin
                ram_index <= addr_q;
                addr_q    <= addr_q + 1'b1;     // natural wrap at 2**ADDR_W
                remain_q  <= remain_q - 1'b1;
                if (remain_q == '0) begin
                    state <= S_IDLE;
                end
            end
            if (accept) begin
                addr_q   <= bus.req_addr;
                remain_q <= bus.req_len;
                state    <= bus.req_write ? S_WRITE : S_READ;
            end
        end
    end

    // Response FIFO storage needs no reset: occupancy is tracked by fifo_count.
    always_ff @(posedge sram_clk) begin
        if (!sram_ares && push) begin
            fifo_mem[wr_ptr] <= sram_data_out;
        end
    end

    always_ff @(posedge sram_clk) begin
        if (sram_ares) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_sram_ctrl.sv
module tb_byte_sram_ctrl;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int RSP_DEPTH = 4;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    logic       sram_clk  = 1'b0;
    logic       sram_ares = 1'b1;
    logic       wr_enable;
    logic       rd_enable;
    logic [6:0] ram_index;
    logic [7:0] sram_data_in;
    logic [7:0] sram_data_out;

    byte_sram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    byte_sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .sram_clk      (sram_clk),
        .sram_ares     (sram_ares),
        .bus           (bus),
        .wr_enable     (wr_enable),
        .rd_enable     (rd_enable),
        .ram_index     (ram_index),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    always #5 sram_clk = ~sram_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge sram_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM environment (128x8, one-cycle read latency) ----
    logic [7:0] sram_mem [128];
    bit         mem_init = 1'b0;

    always @(posedge sram_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) sram_mem[i] <= 8'(i) ^ 8'h5A;
            mem_init <= 1'b1;
        end else if (wr_enable && !rd_enable) begin
            sram_mem[ram_index] <= sram_data_in;
        end
        if (rd_enable && !wr_enable) sram_data_out <= sram_mem[ram_index];
        else                         sram_data_out <= '0;
    end

    // ---------------- transaction-level model and per-cycle compare -------
    logic [7:0] ref_mem [128];
    bit         ref_init = 1'b0;
    wr_t        exp_wr[$];
    logic [6:0] exp_rd[$];
    logic [7:0] exp_rsp[$];
    wr_t        wr_log[$];
    int         wr_cyc[$];
    int         rd_cyc[$];
    int         rsp_cyc[$];
    logic [7:0] rsp_log[$];
    int         outstanding = 0;
    int         stall_cnt   = 0;
    int         acc_cyc     = 0;
    int         w_left      = 0;
    logic [6:0] w_addr      = '0;
    bit         rst_chk     = 1'b0;

    always @(negedge sram_clk) begin
        wr_t        e;
        logic [6:0] ra;
        if (!ref_init) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
            ref_init = 1'b1;
        end
        if (sram_ares) begin
            exp_wr.delete();
            exp_rd.delete();
            exp_rsp.delete();
            w_left      = 0;
            outstanding = 0;
            rst_chk     = 1'b1;
        end else begin
            if (rst_chk) begin
                check("rst_req_ready",   bus.req_ready,   1);
                check("rst_wdata_ready", bus.wdata_ready, 0);
                check("rst_rsp_valid",   bus.rsp_valid,   0);
                check("rst_rsp_data",    bus.rsp_data,    0);
                check("rst_busy",        bus.busy,        0);
                check("rst_wr_enable",   wr_enable,       0);
                check("rst_rd_enable",   rd_enable,       0);
                check("rst_ram_index",   ram_index,       0);
                check("rst_sram_din",    sram_data_in,    0);
                rst_chk = 1'b0;
            end
            check("enable_exclusive", wr_enable & rd_enable, 0);
            check("wr_enable_timing", wr_enable, (exp_wr.size() != 0) ? 1 : 0);
            if (wr_enable && exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_index", ram_index, e.a);
                check("wr_data", sram_data_in, e.d);
                wr_log.push_back({ram_index, sram_data_in});
                wr_cyc.push_back(cyc);
            end
            if (rd_enable) begin
                check("rd_expected", (exp_rd.size() != 0) ? 1 : 0, 1);
                if (exp_rd.size() != 0) check("rd_index", ram_index, exp_rd.pop_front());
                rd_cyc.push_back(cyc);
                outstanding++;
                check("rd_credit", (outstanding <= RSP_DEPTH) ? 1 : 0, 1);
            end
            if (outstanding != 0 || exp_rd.size() != 0 || w_left != 0)
                check("busy_active", bus.busy, 1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", (exp_rsp.size() != 0) ? 1 : 0, 1);
                if (exp_rsp.size() != 0) check("rsp_data", bus.rsp_data, exp_rsp.pop_front());
                rsp_log.push_back(bus.rsp_data);
                rsp_cyc.push_back(cyc);
                outstanding--;
            end
            if (bus.req_valid && !bus.req_ready) stall_cnt++;
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc = cyc;
                if (bus.req_write) begin
                    w_addr = bus.req_addr;
                    w_left = int'(bus.req_len) + 1;
                end else begin
                    for (int i = 0; i <= int'(bus.req_len); i++) begin
                        ra = bus.req_addr + 7'(i);
                        exp_rd.push_back(ra);
                        exp_rsp.push_back(ref_mem[ra]);
                    end
                end
            end
            if (bus.wdata_valid && bus.wdata_ready) begin
                check("beat_in_burst", (w_left != 0) ? 1 : 0, 1);
                exp_wr.push_back({w_addr, bus.wdata});
                ref_mem[w_addr] = bus.wdata;
                w_addr = w_addr + 7'd1;
                w_left--;
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic cmd(input bit w, input int a, input int l);
        int t;
        bus.req_write = w;
        bus.req_addr  = 7'(a);
        bus.req_len   = 7'(l);
        bus.req_valid = 1'b1;
        t = 0;
        @(negedge sram_clk);
        while (!bus.req_ready && t < 500) begin
            @(negedge sram_clk);
            t++;
        end
        check("cmd_handshake", bus.req_ready, 1);
        @(posedge sram_clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic [7:0] base, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int t;
            bus.wdata       = base + 8'(i);
            bus.wdata_valid = 1'b1;
            t = 0;
            @(negedge sram_clk);
            while (!bus.wdata_ready && t < 300) begin
                @(negedge sram_clk);
                t++;
            end
            check("beat_handshake", bus.wdata_ready, 1);
            @(posedge sram_clk);
            #1;
            if (gaps) begin
                bus.wdata_valid = 1'b0;
                @(posedge sram_clk);
                #1;
            end
        end
        bus.wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int  t;
        bit  idle;
        t    = 0;
        idle = 1'b0;
        while (!idle && t < 1000) begin
            @(negedge sram_clk);
            idle = !bus.busy && exp_wr.size() == 0 && exp_rd.size() == 0 &&
                   exp_rsp.size() == 0 && w_left == 0;
            t++;
        end
        check("idle_reached", idle, 1);
        @(posedge sram_clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_wr, b_rd, b_rsp, b_stall, t;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rsp_ready   = 1'b1;
        repeat (3) @(posedge sram_clk);
        #1 sram_ares = 1'b0;
        @(posedge sram_clk);
        #1;

        // Write wrap-around 7E..01, then read it back.
        b_wr = wr_log.size(); b_rsp = rsp_log.size(); b_rd = rd_cyc.size();
        fork
            cmd(1'b1, 'h7E, 3);
            send_beats(4, 8'hA0, 1'b0);
        join
        wait_idle();
        check("wrap_wr_count", wr_log.size() - b_wr, 4);
        check("wrap_idx1", wr_log[b_wr+1].a, 'h7F);
        check("wrap_idx2", wr_log[b_wr+2].a, 'h00);
        check("wrap_contiguous", wr_cyc[b_wr+3] - wr_cyc[b_wr], 3);
        check("wrap_no_reads", rd_cyc.size() - b_rd, 0);
        cmd(1'b0, 'h7E, 3);
        wait_idle();
        for (int i = 0; i < 4; i++) check("wrap_readback", rsp_log[b_rsp+i], 'hA0 + i);

        // Full 128-beat read, rsp_ready held high.
        b_rd = rd_cyc.size(); b_rsp = rsp_log.size();
        cmd(1'b0, 'h00, 'h7F);
        wait_idle();
        check("full_rd_count", rd_cyc.size() - b_rd, 128);
        check("full_rd_no_bubble", rd_cyc[b_rd+127] - rd_cyc[b_rd], 127);
        check("full_rsp_count", rsp_log.size() - b_rsp, 128);
        check("full_first_rsp_lat", rsp_cyc[b_rsp] - rd_cyc[b_rd], 2);
        check("full_rsp0", rsp_log[b_rsp], 'hA2);
        check("full_rsp2", rsp_log[b_rsp+2], 'h58);
        check("full_rsp127", rsp_log[b_rsp+127], 'hA1);

        // Backpressure: 16-beat read with rsp_ready low.
        bus.rsp_ready = 1'b0;
        b_rd = rd_cyc.size(); b_rsp = rsp_log.size();
        cmd(1'b0, 'h20, 15);
        repeat (20) @(posedge sram_clk);
        #1;
        check("bp_issue_stop", rd_cyc.size() - b_rd, RSP_DEPTH);
        check("bp_no_rsp", rsp_log.size() - b_rsp, 0);
        check("bp_busy", bus.busy, 1);
        bus.rsp_ready = 1'b1;
        wait_idle();
        check("bp_rd_total", rd_cyc.size() - b_rd, 16);
        check("bp_rsp_total", rsp_log.size() - b_rsp, 16);
        check("bp_rsp0", rsp_log[b_rsp], 'h7A);
        check("bp_rsp15", rsp_log[b_rsp+15], 'h75);

        // Write with wdata_valid toggling.
        b_wr = wr_log.size(); b_rd = rd_cyc.size();
        fork
            cmd(1'b1, 'h40, 3);
            send_beats(4, 8'hC0, 1'b1);
        join
        wait_idle();
        check("gap_wr_count", wr_log.size() - b_wr, 4);
        check("gap_spacing", wr_cyc[b_wr+1] - wr_cyc[b_wr], 2);
        check("gap_last_data", wr_log[b_wr+3].d, 'hC3);
        check("gap_no_reads", rd_cyc.size() - b_rd, 0);

        // Second command held off during a write burst.
        b_stall = stall_cnt; b_rsp = rsp_log.size();
        fork
            begin
                cmd(1'b1, 'h10, 3);
                cmd(1'b0, 'h10, 3);
            end
            send_beats(4, 8'h30, 1'b0);
        join
        wait_idle();
        check("lock_stall_cycles", stall_cnt - b_stall, 4);
        check("lock_accept_cycle", acc_cyc, wr_cyc[wr_cyc.size()-1]);
        for (int i = 0; i < 4; i++) check("lock_readback", rsp_log[b_rsp+i], 'h30 + i);

        // Reset in beat 5 of a 32-beat read.
        b_rd = rd_cyc.size();
        cmd(1'b0, 'h00, 31);
        t = 0;
        while (rd_cyc.size() - b_rd < 5 && t < 100) begin
            @(posedge sram_clk);
            #1;
            t++;
        end
        check("mid_rst_beat", rd_cyc.size() - b_rd, 5);
        sram_ares = 1'b1;
        @(posedge sram_clk);
        #1;
        sram_ares = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_req_ready", bus.req_ready, 1);
        repeat (4) @(posedge sram_clk);
        #1;
        b_rsp = rsp_log.size();
        cmd(1'b0, 'h7E, 3);
        wait_idle();
        check("post_rst_count", rsp_log.size() - b_rsp, 4);
        check("post_rst_rsp0", rsp_log[b_rsp], 'hA0);
        check("post_rst_rsp3", rsp_log[b_rsp+3], 'hA3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
